// File: rtl/issue_dispatch_pkg.sv
// Shared types, sizes and the free-slot picker for the dispatch stage.
package issue_dispatch_pkg;

   localparam int unsigned NUM_SLOTS = 8;
   localparam int unsigned NUM_REGS  = 32;
   localparam int unsigned REG_W     = $clog2(NUM_REGS);
   localparam int unsigned OPC_W     = 7;

   typedef logic [REG_W-1:0] reg_t;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      reg_t             src1;
      reg_t             src2;
      reg_t             dest;
   } uop_t;

   typedef struct packed {
      logic [NUM_SLOTS-1:0] onehot;
      logic                 found;
   } free_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_e;

   function automatic free_t lowest_free(input logic [NUM_SLOTS-1:0] occ);
      free_t r;
      r.onehot = '0;
      r.found  = 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (!occ[i] && !r.found) begin
            r.onehot[i] = 1'b1;
            r.found     = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/issue_dispatch_if.sv
// Upstream uop handshake, issue-slot write bus and wakeup broadcast.
interface issue_dispatch_if;
   import issue_dispatch_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [OPC_W-1:0]     in_opcode;
   reg_t                 in_src1;
   reg_t                 in_src2;
   reg_t                 in_dest;
   logic [NUM_SLOTS-1:0] slot_valid;
   logic                 wakeup_valid;
   reg_t                 wakeup_dest;
   logic [NUM_SLOTS-1:0] slot_we;
   logic [OPC_W-1:0]     slot_opcode;
   reg_t                 slot_src1;
   reg_t                 slot_src2;
   reg_t                 slot_dest;
   logic                 slot_src1_rdy;
   logic                 slot_src2_rdy;
   logic                 iq_full;

   modport master (
      output in_valid, in_opcode, in_src1, in_src2, in_dest,
             slot_valid, wakeup_valid, wakeup_dest,
      input  in_ready, slot_we, slot_opcode, slot_src1, slot_src2, slot_dest,
             slot_src1_rdy, slot_src2_rdy, iq_full
   );

   modport slave (
      input  in_valid, in_opcode, in_src1, in_src2, in_dest,
             slot_valid, wakeup_valid, wakeup_dest,
      output in_ready, slot_we, slot_opcode, slot_src1, slot_src2, slot_dest,
             slot_src1_rdy, slot_src2_rdy, iq_full
   );

endinterface

// File: rtl/issue_dispatch_busy_table.sv
// Busy-register scoreboard: set by dispatched dests, cleared by wakeups,
// with two read ports that see a same-cycle wakeup as ready.
module issue_dispatch_busy_table
   import issue_dispatch_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_flush,
   input  logic i_set_en,
   input  reg_t i_set_addr,
   input  logic i_clr_en,
   input  reg_t i_clr_addr,
   input  reg_t i_rd1_addr,
   input  reg_t i_rd2_addr,
   output logic o_rd1_rdy,
   output logic o_rd2_rdy
);

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;

   // Set is applied after clear so a new producer wins over an old result.
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_clr_en && (i_clr_addr != '0))
         w_busy_nxt[i_clr_addr] = 1'b0;
      if (i_set_en && (i_set_addr != '0))
         w_busy_nxt[i_set_addr] = 1'b1;
      if (i_flush)
         w_busy_nxt = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   always_comb begin
      o_rd1_rdy = (i_rd1_addr == '0) || !r_busy[i_rd1_addr] ||
                  (i_clr_en && (i_clr_addr == i_rd1_addr));
      o_rd2_rdy = (i_rd2_addr == '0) || !r_busy[i_rd2_addr] ||
                  (i_clr_en && (i_clr_addr == i_rd2_addr));
   end

endmodule

// File: rtl/issue_dispatch.sv
// Dispatch stage: one-entry staging register feeding the lowest free
// issue slot, with scoreboard-derived source readiness and a stall counter.
module issue_dispatch
   import issue_dispatch_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              kill,
   issue_dispatch_if.slave   bus,
   output logic [15:0]       stall_cnt
);

   stage_e      r_state;
   stage_e      w_state_nxt;
   uop_t        r_uop;
   uop_t        w_out;
   free_t       w_free;
   logic        w_write_fire;
   logic        w_accept;
   logic        w_blocked;
   logic        w_src1_rdy;
   logic        w_src2_rdy;
   logic [15:0] r_stall_cnt;

   always_comb begin
      w_free       = lowest_free(bus.slot_valid);
      w_write_fire = (r_state == ST_FULL) && !kill && w_free.found;
      w_blocked    = (r_state == ST_FULL) && !kill && !w_free.found;
      bus.in_ready = !kill && ((r_state == ST_EMPTY) || w_write_fire);
      w_accept     = bus.in_valid && bus.in_ready;
      bus.slot_we  = w_write_fire ? w_free.onehot : '0;
      bus.iq_full  = &bus.slot_valid;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (kill)
         w_state_nxt = ST_EMPTY;
      else if (w_accept)
         w_state_nxt = ST_FULL;
      else if (w_write_fire)
         w_state_nxt = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_EMPTY;
         r_uop   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept)
            r_uop <= '{opcode: bus.in_opcode, src1: bus.in_src1,
                       src2: bus.in_src2, dest: bus.in_dest};
      end
   end

   // Zeroed fields while empty also make the readiness ports report 1.
   always_comb begin
      w_out             = (r_state == ST_FULL) ? r_uop : '0;
      bus.slot_opcode   = w_out.opcode;
      bus.slot_src1     = w_out.src1;
      bus.slot_src2     = w_out.src2;
      bus.slot_dest     = w_out.dest;
      bus.slot_src1_rdy = w_src1_rdy;
      bus.slot_src2_rdy = w_src2_rdy;
   end

   issue_dispatch_busy_table u_busy (
      .clk        (clk),
      .reset      (reset),
      .i_flush    (kill),
      .i_set_en   (w_write_fire),
      .i_set_addr (r_uop.dest),
      .i_clr_en   (bus.wakeup_valid),
      .i_clr_addr (bus.wakeup_dest),
      .i_rd1_addr (w_out.src1),
      .i_rd2_addr (w_out.src2),
      .o_rd1_rdy  (w_src1_rdy),
      .o_rd2_rdy  (w_src2_rdy)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= '0;
      else if (w_blocked && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_dispatch.sv
// Directed bench for issue_dispatch: vector table plus kill, streaming
// and asynchronous-reset sequences.
module tb_issue_dispatch;

   logic        clk;
   logic        reset;
   logic        kill;
   logic [15:0] stall_cnt;

   issue_dispatch_if bus ();

   issue_dispatch dut (
      .clk       (clk),
      .reset     (reset),
      .kill      (kill),
      .bus       (bus),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [6:0] opc;
      logic [4:0] s1;
      logic [4:0] s2;
      logic [4:0] d;
      logic [7:0] sv;
      logic       wk_v;
      logic [4:0] wk_d;
      logic       e_ready;
      logic [7:0] e_we;
      logic       e_chk;
      logic [6:0] e_opc;
      logic       e_r1;
      logic       e_r2;
      logic       e_full;
      logic [15:0] e_stall;
   } vec_t;

   vec_t vecs[15];
   int   n_cmp = 0;
   int   n_mis = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d, input logic [7:0] sv,
                        input logic wk_v, input logic [4:0] wk_d);
      bus.in_valid     = v;
      bus.in_opcode    = opc;
      bus.in_src1      = s1;
      bus.in_src2      = s2;
      bus.in_dest      = d;
      bus.slot_valid   = sv;
      bus.wakeup_valid = wk_v;
      bus.wakeup_dest  = wk_d;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] sv_m;
      logic [7:0] exp_we;

      //          v  opc    s1 s2 d  sv     wk wkd  rdy we     chk opc    r1 r2 full stall
      vecs[0]  = '{1, 7'h11, 1, 2, 3, 8'h00, 0, 0,   1, 8'h00, 0, 7'h00, 1, 1, 0, 0};
      vecs[1]  = '{1, 7'h22, 3, 0, 4, 8'h00, 0, 0,   1, 8'h01, 1, 7'h11, 1, 1, 0, 0};
      vecs[2]  = '{1, 7'h33, 3, 4, 0, 8'h00, 0, 0,   1, 8'h01, 1, 7'h22, 0, 1, 0, 0};
      vecs[3]  = '{1, 7'h44, 3, 4, 5, 8'h00, 1, 3,   1, 8'h01, 1, 7'h33, 1, 0, 0, 0};
      vecs[4]  = '{1, 7'h55, 3, 5, 5, 8'h00, 1, 5,   1, 8'h01, 1, 7'h44, 1, 0, 0, 0};
      vecs[5]  = '{1, 7'h66, 7, 0, 7, 8'h00, 0, 0,   1, 8'h01, 1, 7'h55, 1, 0, 0, 0};
      vecs[6]  = '{0, 7'h00, 0, 0, 0, 8'h00, 1, 0,   1, 8'h01, 1, 7'h66, 1, 1, 0, 0};
      vecs[7]  = '{1, 7'h77, 0, 7, 0, 8'h00, 0, 0,   1, 8'h00, 0, 7'h00, 1, 1, 0, 0};
      vecs[8]  = '{0, 7'h00, 0, 0, 0, 8'h00, 1, 0,   1, 8'h01, 1, 7'h77, 1, 0, 0, 0};
      vecs[9]  = '{1, 7'h08, 4, 0, 6, 8'hFF, 0, 0,   1, 8'h00, 0, 7'h00, 1, 1, 1, 0};
      vecs[10] = '{1, 7'h09, 6, 5, 0, 8'hFF, 0, 0,   0, 8'h00, 1, 7'h08, 0, 1, 1, 0};
      vecs[11] = '{1, 7'h09, 6, 5, 0, 8'hFF, 0, 0,   0, 8'h00, 1, 7'h08, 0, 1, 1, 1};
      vecs[12] = '{1, 7'h09, 6, 5, 0, 8'hFF, 0, 0,   0, 8'h00, 1, 7'h08, 0, 1, 1, 2};
      vecs[13] = '{1, 7'h09, 6, 5, 0, 8'hEF, 0, 0,   1, 8'h10, 1, 7'h08, 0, 1, 0, 3};
      vecs[14] = '{0, 7'h00, 0, 0, 0, 8'hEF, 0, 0,   1, 8'h10, 1, 7'h09, 0, 0, 0, 3};

      reset = 1'b0;
      kill  = 1'b0;
      drive(0, 0, 0, 0, 0, 8'h00, 0, 0);
      @(negedge clk);
      #1;
      chk("reset in_ready", 32'(bus.in_ready), 1);
      chk("reset slot_we", 32'(bus.slot_we), 0);
      chk("reset slot_opcode", 32'(bus.slot_opcode), 0);
      chk("reset stall_cnt", 32'(stall_cnt), 0);
      chk("reset iq_full", 32'(bus.iq_full), 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].v, vecs[i].opc, vecs[i].s1, vecs[i].s2, vecs[i].d,
               vecs[i].sv, vecs[i].wk_v, vecs[i].wk_d);
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ready));
         chk($sformatf("vec%0d slot_we", i), 32'(bus.slot_we), 32'(vecs[i].e_we));
         chk($sformatf("vec%0d iq_full", i), 32'(bus.iq_full), 32'(vecs[i].e_full));
         chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_stall));
         if (vecs[i].e_chk) begin
            chk($sformatf("vec%0d slot_opcode", i), 32'(bus.slot_opcode), 32'(vecs[i].e_opc));
            chk($sformatf("vec%0d src1_rdy", i), 32'(bus.slot_src1_rdy), 32'(vecs[i].e_r1));
            chk($sformatf("vec%0d src2_rdy", i), 32'(bus.slot_src2_rdy), 32'(vecs[i].e_r2));
         end
         tick();
      end

      // kill while staged: busy 4..7 are set at this point
      drive(1, 7'h0A, 1, 2, 3, 8'h00, 0, 0);
      tick();
      kill = 1'b1;
      drive(1, 7'h0D, 1, 2, 3, 8'h00, 0, 0);
      #1;
      chk("kill in_ready", 32'(bus.in_ready), 0);
      chk("kill slot_we", 32'(bus.slot_we), 0);
      tick();
      kill = 1'b0;
      drive(1, 7'h0B, 4, 5, 0, 8'h00, 0, 0);
      #1;
      chk("post-kill in_ready", 32'(bus.in_ready), 1);
      chk("post-kill slot_we", 32'(bus.slot_we), 0);
      chk("post-kill slot_opcode", 32'(bus.slot_opcode), 0);
      tick();
      drive(1, 7'h0C, 6, 7, 0, 8'h00, 0, 0);
      #1;
      chk("post-kill L slot_we", 32'(bus.slot_we), 32'h01);
      chk("post-kill L opcode", 32'(bus.slot_opcode), 32'h0B);
      chk("post-kill L src1_rdy", 32'(bus.slot_src1_rdy), 1);
      chk("post-kill L src2_rdy", 32'(bus.slot_src2_rdy), 1);
      tick();
      drive(0, 0, 0, 0, 0, 8'h00, 0, 0);
      #1;
      chk("post-kill M opcode", 32'(bus.slot_opcode), 32'h0C);
      chk("post-kill M src1_rdy", 32'(bus.slot_src1_rdy), 1);
      chk("post-kill M src2_rdy", 32'(bus.slot_src2_rdy), 1);
      chk("post-kill stall_cnt", 32'(stall_cnt), 3);
      tick();

      // streaming eight uops into an empty queue
      sv_m = 8'h00;
      for (int i = 0; i <= 8; i++) begin
         drive(i < 8, 7'(7'h40 + i), 0, 0, 0, sv_m, 0, 0);
         exp_we = (i == 0) ? 8'h00 : 8'(8'h01 << (i - 1));
         #1;
         chk($sformatf("stream%0d slot_we", i), 32'(bus.slot_we), 32'(exp_we));
         chk($sformatf("stream%0d in_ready", i), 32'(bus.in_ready), 1);
         tick();
         sv_m = sv_m | exp_we;
      end
      drive(0, 0, 0, 0, 0, sv_m, 0, 0);
      #1;
      chk("stream end iq_full", 32'(bus.iq_full), 1);
      chk("stream end slot_we", 32'(bus.slot_we), 0);

      // asynchronous reset with a uop about to be written
      drive(1, 7'h5A, 0, 0, 9, 8'h00, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 8'h00, 0, 0);
      #1;
      chk("pre-reset slot_we", 32'(bus.slot_we), 32'h01);
      chk("pre-reset opcode", 32'(bus.slot_opcode), 32'h5A);
      #1;
      reset = 1'b0;
      #1;
      chk("async reset slot_we", 32'(bus.slot_we), 0);
      chk("async reset in_ready", 32'(bus.in_ready), 1);
      chk("async reset opcode", 32'(bus.slot_opcode), 0);
      chk("async reset stall_cnt", 32'(stall_cnt), 0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
